// File: rtl/freq_sweep_pkg.sv
// freq_sweep_pkg: shared types and helpers for the resonance-search controller.
//   sweepState_e : controller FSM states
//   mag()        : distance of an unsigned ADC sample from the nearer rail
package freq_sweep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStartup,
        StSettle,
        StAccum,
        StEval,
        StDone
    } sweepState_e;

    // Sample magnitude for a w-bit unsigned sample (w < 32). The lower half of the
    // code range reads as-is; the upper half is folded to its distance from all-ones.
    function automatic logic [31:0] mag(input logic [31:0] x, input int unsigned w);
        logic [31:0] full;
        logic [31:0] half;
        full = (32'd1 << w) - 32'd1;
        half = 32'd1 << (w - 1);
        if (x < half) begin
            return x;
        end
        return full - x;
    endfunction

endpackage

// File: rtl/freq_sweep_ctrl_if.sv
// freq_sweep_ctrl_if: bundle between the sweep controller, the ADC front end and
// the power-stage frequency register.
//   alive, go, mode        : link status, sweep request, sweep mode
//   adc, adc_valid         : ADC sample and its one-cycle strobe
//   freq_out               : drive frequency to the power stage
//   best_freq, best_mag    : best point found so far and its averaged magnitude
//   busy, done             : sweep in progress / sweep finished
// master drives the request and ADC side; slave is the controller.
interface freq_sweep_ctrl_if #(
    parameter int unsigned FREQ_W = 20,
    parameter int unsigned ADC_W  = 12
) ();

    logic              alive;
    logic              go;
    logic              mode;
    logic [ADC_W-1:0]  adc;
    logic              adc_valid;
    logic [FREQ_W-1:0] freq_out;
    logic [FREQ_W-1:0] best_freq;
    logic [ADC_W-1:0]  best_mag;
    logic              busy;
    logic              done;

    modport master (
        output alive, go, mode, adc, adc_valid,
        input  freq_out, best_freq, best_mag, busy, done
    );

    modport slave (
        input  alive, go, mode, adc, adc_valid,
        output freq_out, best_freq, best_mag, busy, done
    );

endinterface

// File: rtl/adc_avg_accum.sv
// adc_avg_accum: sums 2^AVG_LOG2 sample magnitudes and presents their average.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clears count, sum and valid (asserted on SETTLE entry)
//   sampleEn   : take sampleMag this cycle
//   sampleMag  : magnitude of the current sample
//   last       : the sample taken this cycle completes the set (combinational)
//   avg        : sum >> AVG_LOG2
//   avgValid   : one-cycle pulse in the cycle after the last sample was taken
module adc_avg_accum #(
    parameter int unsigned ADC_W    = 12,
    parameter int unsigned AVG_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sampleEn,
    input  logic [ADC_W-1:0] sampleMag,
    output logic             last,
    output logic [ADC_W-1:0] avg,
    output logic             avgValid
);

    localparam int unsigned SumW = ADC_W + AVG_LOG2;
    localparam int unsigned CntW = AVG_LOG2 + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'((32'd1 << AVG_LOG2) - 32'd1);

    logic [CntW-1:0] cntQ;
    logic [SumW-1:0] sumQ;
    logic            validQ;

    assign last     = sampleEn && (cntQ == LastCnt);
    assign avg      = ADC_W'(sumQ >> AVG_LOG2);
    assign avgValid = validQ;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cntQ   <= '0;
            sumQ   <= '0;
            validQ <= 1'b0;
        end else begin
            validQ <= last;
            if (sampleEn) begin
                sumQ <= sumQ + SumW'(sampleMag);
                cntQ <= cntQ + 1'b1;
            end
        end
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: resonance-search controller. Steps the drive frequency across
// [F_START, F_STOP], settles at each point, averages 2^AVG_LOG2 ADC magnitudes and
// keeps the frequency with the highest average. mode 0 runs one linear pass at
// FINE_STEP; mode 1 runs a coarse pass then a fine pass around the coarse best.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of freq_sweep_ctrl_if (request, ADC, results)
module freq_sweep_ctrl
    import freq_sweep_pkg::*;
#(
    parameter int unsigned FREQ_W      = 20,
    parameter int unsigned ADC_W       = 12,
    parameter int unsigned F_START     = 35000,
    parameter int unsigned F_STOP      = 45000,
    parameter int unsigned COARSE_STEP = 500,
    parameter int unsigned FINE_STEP   = 50,
    parameter int unsigned STARTUP_CYC = 200000,
    parameter int unsigned SETTLE_CYC  = 200000,
    parameter int unsigned AVG_LOG2    = 4
) (
    input logic               clk,
    input logic               rst,
    freq_sweep_ctrl_if.slave  bus
);

    localparam int unsigned ExtW = FREQ_W + 1;

    typedef logic [FREQ_W-1:0] freq_t;
    typedef logic [ExtW-1:0]   freqExt_t;

    localparam freq_t    FStart    = FREQ_W'(F_START);
    localparam freqExt_t FStartExt = ExtW'(F_START);
    localparam freqExt_t FStopExt  = ExtW'(F_STOP);
    localparam freqExt_t CoarseExt = ExtW'(COARSE_STEP);
    localparam freqExt_t FineExt   = ExtW'(FINE_STEP);

    sweepState_e      stateQ, stateD;
    logic [31:0]      cntQ, cntD;
    freq_t            freqQ, freqD;
    freq_t            bestFreqQ, bestFreqD;
    logic [ADC_W-1:0] bestMagQ, bestMagD;
    logic             modeQ, modeD;
    logic             fineQ, fineD;    // currently in the fine pass of mode 1
    freqExt_t         fineHiQ, fineHiD;

    // Accumulator hookup
    logic             accClr;
    logic             sampleEn;
    logic [ADC_W-1:0] sampleMag;
    logic             accLast;
    logic [ADC_W-1:0] accAvg;
    logic             accValid;

    logic             abortReq;

    // Evaluation of the point just measured; strict compare keeps the lower
    // frequency on ties because the sweep always runs upward.
    logic             evalUpdate;
    freq_t            evalBestFreq;
    logic [ADC_W-1:0] evalBestMag;
    freqExt_t         evalStep;
    freqExt_t         evalNext;
    freqExt_t         evalUpper;
    freqExt_t         bestExt;
    freqExt_t         fineLo;
    freqExt_t         fineHi;

    // go falling in DONE is the normal exit and keeps the results; alive low
    // anywhere, or go low mid-sweep, is an abort.
    assign abortReq = (stateQ != StIdle) &&
                      (!bus.alive || ((stateQ != StDone) && !bus.go));

    assign sampleMag = ADC_W'(mag(32'(bus.adc), ADC_W));
    assign sampleEn  = (stateQ == StAccum) && bus.adc_valid && !abortReq;

    adc_avg_accum #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .clr       (accClr),
        .sampleEn  (sampleEn),
        .sampleMag (sampleMag),
        .last      (accLast),
        .avg       (accAvg),
        .avgValid  (accValid)
    );

    assign evalUpdate   = accValid && (accAvg > bestMagQ);
    assign evalBestFreq = evalUpdate ? freqQ : bestFreqQ;
    assign evalBestMag  = evalUpdate ? accAvg : bestMagQ;
    assign evalStep     = (modeQ && !fineQ) ? CoarseExt : FineExt;
    assign evalNext     = {1'b0, freqQ} + evalStep;
    assign evalUpper    = fineQ ? fineHiQ : FStopExt;

    // Fine window around the coarse best, clamped to the band without wrapping.
    assign bestExt = {1'b0, evalBestFreq};
    assign fineLo  = (bestExt >= FStartExt + CoarseExt) ? (bestExt - CoarseExt) : FStartExt;
    assign fineHi  = (bestExt + CoarseExt > FStopExt) ? FStopExt : (bestExt + CoarseExt);

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        freqD     = freqQ;
        bestFreqD = bestFreqQ;
        bestMagD  = bestMagQ;
        modeD     = modeQ;
        fineD     = fineQ;
        fineHiD   = fineHiQ;
        accClr    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (bus.go && bus.alive) begin
                    stateD    = StStartup;
                    cntD      = '0;
                    modeD     = bus.mode;
                    fineD     = 1'b0;
                    bestMagD  = '0;
                    bestFreqD = FStart;
                end
            end
            StStartup: begin
                if (cntQ + 32'd1 >= STARTUP_CYC) begin
                    stateD = StSettle;
                    cntD   = '0;
                    freqD  = FStart;
                    accClr = 1'b1;
                end else begin
                    cntD = cntQ + 32'd1;
                end
            end
            StSettle: begin
                if (cntQ + 32'd1 >= SETTLE_CYC) begin
                    stateD = StAccum;
                    cntD   = '0;
                end else begin
                    cntD = cntQ + 32'd1;
                end
            end
            StAccum: begin
                if (accLast) begin
                    stateD = StEval;
                end
            end
            StEval: begin
                bestFreqD = evalBestFreq;
                bestMagD  = evalBestMag;
                cntD      = '0;
                if (evalNext <= evalUpper) begin
                    stateD = StSettle;
                    freqD  = evalNext[FREQ_W-1:0];
                    accClr = 1'b1;
                end else if (modeQ && !fineQ) begin
                    stateD  = StSettle;
                    fineD   = 1'b1;
                    fineHiD = fineHi;
                    freqD   = fineLo[FREQ_W-1:0];
                    accClr  = 1'b1;
                end else begin
                    stateD = StDone;
                    freqD  = evalBestFreq;
                end
            end
            StDone: begin
                if (!bus.go) begin
                    stateD = StIdle;
                    freqD  = FStart;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        if (abortReq) begin
            stateD    = StIdle;
            cntD      = '0;
            freqD     = FStart;
            bestFreqD = FStart;
            bestMagD  = '0;
            fineD     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            cntQ      <= '0;
            freqQ     <= FStart;
            bestFreqQ <= FStart;
            bestMagQ  <= '0;
            modeQ     <= 1'b0;
            fineQ     <= 1'b0;
            fineHiQ   <= FStopExt;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            freqQ     <= freqD;
            bestFreqQ <= bestFreqD;
            bestMagQ  <= bestMagD;
            modeQ     <= modeD;
            fineQ     <= fineD;
            fineHiQ   <= fineHiD;
        end
    end

    assign bus.freq_out  = freqQ;
    assign bus.best_freq = bestFreqQ;
    assign bus.best_mag  = bestMagQ;
    assign bus.busy      = (stateQ == StStartup) || (stateQ == StSettle) ||
                           (stateQ == StAccum)   || (stateQ == StEval);
    assign bus.done      = (stateQ == StDone);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed bench for freq_sweep_ctrl with a small resonance
// model that picks the ADC value from the current drive frequency.
module tb_freq_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   pattern  = 0;

    always #5 clk = ~clk;

    freq_sweep_ctrl_if #(.FREQ_W(20), .ADC_W(12)) bus ();

    freq_sweep_ctrl #(
        .FREQ_W      (20),
        .ADC_W       (12),
        .F_START     (100),
        .F_STOP      (200),
        .COARSE_STEP (50),
        .FINE_STEP   (10),
        .STARTUP_CYC (8),
        .SETTLE_CYC  (4),
        .AVG_LOG2    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Resonance model
    always_comb begin
        bus.adc = 12'h100;
        case (pattern)
            0: bus.adc = (bus.freq_out == 20'd150) ? 12'h7F0 : 12'h100;
            1: begin
                if (bus.freq_out == 20'd160)      bus.adc = 12'h700;
                else if (bus.freq_out == 20'd150) bus.adc = 12'h600;
                else if (bus.freq_out == 20'd100 || bus.freq_out == 20'd200) bus.adc = 12'h100;
                else bus.adc = 12'h200;
            end
            2: bus.adc = 12'h400;
            3: bus.adc = (bus.freq_out == 20'd170) ? 12'hFF0 : 12'h010;
            default: bus.adc = 12'h100;
        endcase
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Raise go and wait for done; returns the cycle done appeared (0 on timeout)
    // and how many times freq_out moved while busy.
    task automatic runSweep(input logic m, output int doneCyc, output int changes);
        logic [19:0] prev;
        @(negedge clk);
        bus.mode  = m;
        bus.alive = 1'b1;
        bus.go    = 1'b1;
        doneCyc   = 0;
        changes   = 0;
        prev      = bus.freq_out;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy && bus.freq_out != prev) changes++;
            prev = bus.freq_out;
            if (bus.done) begin
                doneCyc = i;
                break;
            end
        end
    endtask

    task automatic releaseGo(input string tag, input logic [19:0] expBest);
        @(negedge clk);
        bus.go = 1'b0;
        @(posedge clk);
        #1;
        checkEq({tag, "_rel_done"}, 32'(bus.done), 32'd0);
        checkEq({tag, "_rel_freq"}, 32'(bus.freq_out), 32'd100);
        checkEq({tag, "_rel_best"}, 32'(bus.best_freq), 32'(expBest));
    endtask

    int doneCyc;
    int changes;
    int found;

    initial begin
        rst           = 1'b1;
        bus.go        = 1'b0;
        bus.alive     = 1'b1;
        bus.mode      = 1'b0;
        bus.adc_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkEq("rst_freq", 32'(bus.freq_out), 32'd100);
        checkEq("rst_best_freq", 32'(bus.best_freq), 32'd100);
        checkEq("rst_best_mag", 32'(bus.best_mag), 32'd0);
        checkEq("rst_busy", 32'(bus.busy), 32'd0);
        checkEq("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // mode 0: peak at 150; 11 points of 7 cycles after 8 startup cycles
        pattern = 0;
        runSweep(1'b0, doneCyc, changes);
        checkEq("m0_done_cyc", 32'(doneCyc), 32'd86);
        checkEq("m0_steps", 32'(changes), 32'd10);
        checkEq("m0_best_freq", 32'(bus.best_freq), 32'd150);
        checkEq("m0_best_mag", 32'(bus.best_mag), 32'h7F0);
        checkEq("m0_freq_out", 32'(bus.freq_out), 32'd150);
        checkEq("m0_busy", 32'(bus.busy), 32'd0);
        releaseGo("m0", 20'd150);

        // mode 1: coarse 100/150/200 then fine 100..200, peak at 160
        pattern = 1;
        runSweep(1'b1, doneCyc, changes);
        checkEq("m1_done_cyc", 32'(doneCyc), 32'd107);
        checkEq("m1_steps", 32'(changes), 32'd13);
        checkEq("m1_best_freq", 32'(bus.best_freq), 32'd160);
        checkEq("m1_best_mag", 32'(bus.best_mag), 32'h700);
        checkEq("m1_freq_out", 32'(bus.freq_out), 32'd160);
        releaseGo("m1", 20'd160);

        // Ties keep the lowest frequency
        pattern = 2;
        runSweep(1'b0, doneCyc, changes);
        checkEq("tie_done_cyc", 32'(doneCyc), 32'd86);
        checkEq("tie_best_freq", 32'(bus.best_freq), 32'd100);
        checkEq("tie_best_mag", 32'(bus.best_mag), 32'h400);
        checkEq("tie_freq_out", 32'(bus.freq_out), 32'd100);
        releaseGo("tie", 20'd100);

        // Upper-rail sample folds to a small magnitude
        pattern = 3;
        runSweep(1'b0, doneCyc, changes);
        checkEq("rail_best_freq", 32'(bus.best_freq), 32'd100);
        checkEq("rail_best_mag", 32'(bus.best_mag), 32'h010);
        releaseGo("rail", 20'd100);

        // Abort by alive low in the 3rd SETTLE (freq 120)
        pattern = 0;
        @(negedge clk);
        bus.mode = 1'b0;
        bus.go   = 1'b1;
        found    = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy && bus.freq_out == 20'd120) begin
                found = 1;
                break;
            end
        end
        checkEq("abort_reach", 32'(found), 32'd1);
        checkEq("abort_pre_mag", 32'(bus.best_mag), 32'h100);
        @(negedge clk);
        bus.alive = 1'b0;
        @(posedge clk);
        #1;
        checkEq("abort_busy", 32'(bus.busy), 32'd0);
        checkEq("abort_done", 32'(bus.done), 32'd0);
        checkEq("abort_freq", 32'(bus.freq_out), 32'd100);
        checkEq("abort_best_mag", 32'(bus.best_mag), 32'd0);
        checkEq("abort_best_freq", 32'(bus.best_freq), 32'd100);
        @(negedge clk);
        bus.go    = 1'b0;
        bus.alive = 1'b1;
        runSweep(1'b0, doneCyc, changes);
        checkEq("rerun_done_cyc", 32'(doneCyc), 32'd86);
        checkEq("rerun_best_freq", 32'(bus.best_freq), 32'd150);
        checkEq("rerun_best_mag", 32'(bus.best_mag), 32'h7F0);
        releaseGo("rerun", 20'd150);

        // Reset during the second point's ACCUM (cycle 20, freq 110)
        @(negedge clk);
        bus.go = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkEq("mid_freq", 32'(bus.freq_out), 32'd110);
        checkEq("mid_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkEq("mrst_freq", 32'(bus.freq_out), 32'd100);
        checkEq("mrst_busy", 32'(bus.busy), 32'd0);
        checkEq("mrst_done", 32'(bus.done), 32'd0);
        checkEq("mrst_best_mag", 32'(bus.best_mag), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        bus.go = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
